// File: rtl/eth_frame_arb_mux.sv
// eth_frame_arb_mux: frame-granular arbiter sharing one Ethernet
// header + payload sink among S_COUNT sources.
module eth_frame_arb_mux #(
  parameter int S_COUNT         = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int KEEP_ENABLE     = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH      = (DATA_WIDTH / 8),
  parameter int ARB_ROUND_ROBIN = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [S_COUNT-1:0]               s_eth_hdr_valid,
  output logic [S_COUNT-1:0]               s_eth_hdr_ready,
  input  logic [S_COUNT*48-1:0]            s_eth_dest_mac,
  input  logic [S_COUNT*48-1:0]            s_eth_src_mac,
  input  logic [S_COUNT*16-1:0]            s_eth_type,
  input  logic [S_COUNT*DATA_WIDTH-1:0]    s_eth_payload_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_eth_payload_axis_tkeep,
  input  logic [S_COUNT-1:0]               s_eth_payload_axis_tvalid,
  output logic [S_COUNT-1:0]               s_eth_payload_axis_tready,
  input  logic [S_COUNT-1:0]               s_eth_payload_axis_tlast,
  input  logic [S_COUNT-1:0]               s_eth_payload_axis_tuser,
  output logic                             m_eth_hdr_valid,
  input  logic                             m_eth_hdr_ready,
  output logic [47:0]                      m_eth_dest_mac,
  output logic [47:0]                      m_eth_src_mac,
  output logic [15:0]                      m_eth_type,
  output logic [DATA_WIDTH-1:0]            m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_eth_payload_axis_tkeep,
  output logic                             m_eth_payload_axis_tvalid,
  input  logic                             m_eth_payload_axis_tready,
  output logic                             m_eth_payload_axis_tlast,
  output logic                             m_eth_payload_axis_tuser,
  output logic [$clog2(S_COUNT)-1:0]       grant_index,
  output logic                             busy
);

  localparam int IW = $clog2(S_COUNT);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t state, state_next;

  logic [IW-1:0]         ptr, base, win;
  logic                  found, grant, int_valid, last_acc;
  logic                  int_ready_reg, int_ready_early;
  logic [DATA_WIDTH-1:0] sel_data, temp_data;
  logic [KEEP_WIDTH-1:0] sel_keep, temp_keep;
  logic                  sel_last, sel_user;
  logic                  temp_valid, temp_last, temp_user;

  assign base = (ARB_ROUND_ROBIN != 0) ? ptr : '0;

  // first requester at or after base, wrapping around
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < S_COUNT; k++) begin
      if (!found && s_eth_hdr_valid[(int'(base) + k) % S_COUNT]) begin
        found = 1'b1;
        win   = IW'((int'(base) + k) % S_COUNT);
      end
    end
  end

  assign sel_data = s_eth_payload_axis_tdata[grant_index*DATA_WIDTH +: DATA_WIDTH];
  assign sel_keep = (KEEP_ENABLE != 0)
                  ? s_eth_payload_axis_tkeep[grant_index*KEEP_WIDTH +: KEEP_WIDTH]
                  : {KEEP_WIDTH{1'b1}};
  assign sel_last = s_eth_payload_axis_tlast[grant_index];
  assign sel_user = s_eth_payload_axis_tuser[grant_index];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next                = state;
    grant                     = 1'b0;
    int_valid                 = 1'b0;
    last_acc                  = 1'b0;
    s_eth_hdr_ready           = '0;
    s_eth_payload_axis_tready = '0;
    unique case (state)
      IDLE: begin
        if (!rst && found && (!m_eth_hdr_valid || m_eth_hdr_ready)) begin
          grant                = 1'b1;
          s_eth_hdr_ready[win] = 1'b1;
          state_next           = FRAME;
        end
      end
      FRAME: begin
        s_eth_payload_axis_tready[grant_index] = int_ready_reg;
        int_valid = int_ready_reg && s_eth_payload_axis_tvalid[grant_index];
        if (int_valid && sel_last) begin
          last_acc   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_eth_hdr_valid <= 1'b0;
      m_eth_dest_mac  <= '0;
      m_eth_src_mac   <= '0;
      m_eth_type      <= '0;
      grant_index     <= '0;
      busy            <= 1'b0;
      ptr             <= '0;
    end else begin
      if (grant) begin
        m_eth_hdr_valid <= 1'b1;
        m_eth_dest_mac  <= s_eth_dest_mac[win*48 +: 48];
        m_eth_src_mac   <= s_eth_src_mac[win*48 +: 48];
        m_eth_type      <= s_eth_type[win*16 +: 16];
        grant_index     <= win;
        busy            <= 1'b1;
        ptr             <= (win == IW'(S_COUNT - 1)) ? '0 : win + 1'b1;
      end else begin
        if (m_eth_hdr_ready) m_eth_hdr_valid <= 1'b0;
        if (last_acc)        busy            <= 1'b0;
      end
    end
  end

  // ready only when the sink drains or both skid slots are empty
  assign int_ready_early = m_eth_payload_axis_tready ||
                           (!m_eth_payload_axis_tvalid && !temp_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_ready_reg             <= 1'b0;
      m_eth_payload_axis_tvalid <= 1'b0;
      m_eth_payload_axis_tdata  <= '0;
      m_eth_payload_axis_tkeep  <= '0;
      m_eth_payload_axis_tlast  <= 1'b0;
      m_eth_payload_axis_tuser  <= 1'b0;
      temp_valid                <= 1'b0;
      temp_data                 <= '0;
      temp_keep                 <= '0;
      temp_last                 <= 1'b0;
      temp_user                 <= 1'b0;
    end else begin
      int_ready_reg <= int_ready_early;
      if (int_ready_reg) begin
        if (m_eth_payload_axis_tready || !m_eth_payload_axis_tvalid) begin
          m_eth_payload_axis_tvalid <= int_valid;
          m_eth_payload_axis_tdata  <= sel_data;
          m_eth_payload_axis_tkeep  <= sel_keep;
          m_eth_payload_axis_tlast  <= sel_last;
          m_eth_payload_axis_tuser  <= sel_user;
        end else begin
          temp_valid <= int_valid;
          temp_data  <= sel_data;
          temp_keep  <= sel_keep;
          temp_last  <= sel_last;
          temp_user  <= sel_user;
        end
      end else if (m_eth_payload_axis_tready) begin
        m_eth_payload_axis_tvalid <= temp_valid;
        m_eth_payload_axis_tdata  <= temp_data;
        m_eth_payload_axis_tkeep  <= temp_keep;
        m_eth_payload_axis_tlast  <= temp_last;
        m_eth_payload_axis_tuser  <= temp_user;
        temp_valid                <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_arb_mux.sv
// tb_eth_frame_arb_mux: directed scoreboard bench for the frame
// arbiter, plus a fixed-priority instance with static requests.
module tb_eth_frame_arb_mux;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [S-1:0]    s_hdr_valid, s_hdr_ready;
  logic [S*48-1:0] s_dest, s_src;
  logic [S*16-1:0] s_type;
  logic [S*8-1:0]  s_tdata;
  logic [S-1:0]    s_tkeep, s_tvalid, s_tready, s_tlast, s_tuser;
  logic            m_hdr_valid, m_hdr_ready;
  logic [47:0]     m_dest, m_src;
  logic [15:0]     m_type;
  logic [7:0]      m_tdata;
  logic [0:0]      m_tkeep;
  logic            m_tvalid, m_tready, m_tlast, m_tuser;
  logic [1:0]      gidx;
  logic            busy;

  logic [S-1:0]    f_hdr_ready, f_tready;
  logic            f_hdr_valid, f_tvalid, f_tlast, f_tuser, f_busy;
  logic [47:0]     f_dest, f_src;
  logic [15:0]     f_type;
  logic [7:0]      f_tdata;
  logic [0:0]      f_tkeep;
  logic [1:0]      f_gidx;

  eth_frame_arb_mux dut (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(s_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
    .s_eth_payload_axis_tvalid(s_tvalid), .s_eth_payload_axis_tready(s_tready),
    .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
    .m_eth_hdr_valid(m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
    .m_eth_dest_mac(m_dest), .m_eth_src_mac(m_src), .m_eth_type(m_type),
    .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tkeep(m_tkeep),
    .m_eth_payload_axis_tvalid(m_tvalid), .m_eth_payload_axis_tready(m_tready),
    .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser),
    .grant_index(gidx), .busy(busy)
  );

  eth_frame_arb_mux #(.ARB_ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(4'b1010), .s_eth_hdr_ready(f_hdr_ready),
    .s_eth_dest_mac({S*48{1'b0}}), .s_eth_src_mac({S*48{1'b0}}),
    .s_eth_type({S*16{1'b0}}),
    .s_eth_payload_axis_tdata({S*8{1'b0}}), .s_eth_payload_axis_tkeep(4'b1111),
    .s_eth_payload_axis_tvalid(4'b1010), .s_eth_payload_axis_tready(f_tready),
    .s_eth_payload_axis_tlast(4'b1111), .s_eth_payload_axis_tuser(4'b0000),
    .m_eth_hdr_valid(f_hdr_valid), .m_eth_hdr_ready(1'b1),
    .m_eth_dest_mac(f_dest), .m_eth_src_mac(f_src), .m_eth_type(f_type),
    .m_eth_payload_axis_tdata(f_tdata), .m_eth_payload_axis_tkeep(f_tkeep),
    .m_eth_payload_axis_tvalid(f_tvalid), .m_eth_payload_axis_tready(1'b1),
    .m_eth_payload_axis_tlast(f_tlast), .m_eth_payload_axis_tuser(f_tuser),
    .grant_index(f_gidx), .busy(f_busy)
  );

  logic [15:0] hq [S][$];
  logic [9:0]  bq [S][$];
  logic [17:0] exp_hdr [$];
  logic [9:0]  exp_beat [$];
  int          exp_grant [$];

  int   checks = 0;
  int   errors = 0;
  logic bp;
  int   hdr_hold;
  logic pend;
  int   pend_g;
  int   hdr_fires, out_beats, fp_grants;

  function automatic logic [47:0] dmac(int i);
    return 48'h0200_0000_0000 | 48'(i);
  endfunction

  function automatic logic [47:0] smac(int i);
    return 48'h0a00_0000_0000 | 48'(i);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(int src, logic [15:0] ty, int n,
                           logic [7:0] d0, logic [7:0] step, logic usr);
    hq[src].push_back(ty);
    exp_grant.push_back(src);
    exp_hdr.push_back({2'(src), ty});
    for (int k = 0; k < n; k++) begin
      logic [9:0] b;
      b = {usr && (k == n - 1), k == n - 1, d0 + 8'(k) * step};
      bq[src].push_back(b);
      exp_beat.push_back(b);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < S; i++) begin
      s_hdr_valid[i]     = hq[i].size() != 0;
      s_type[i*16 +: 16] = (hq[i].size() != 0) ? hq[i][0] : 16'h0;
      s_dest[i*48 +: 48] = dmac(i);
      s_src[i*48 +: 48]  = smac(i);
      s_tvalid[i]        = bq[i].size() != 0;
      {s_tuser[i], s_tlast[i], s_tdata[i*8 +: 8]} =
        (bq[i].size() != 0) ? bq[i][0] : 10'h0;
    end
    s_tkeep     = '1;
    m_tready    = bp ? ~m_tready : 1'b1;
    m_hdr_ready = (hdr_hold == 0);
    if (hdr_hold > 0) hdr_hold--;
  endtask

  task automatic sample();
    logic [17:0] e;
    logic [9:0]  b;
    int          g;
    if (pend) begin
      chk("hdr_valid_lat", 64'(m_hdr_valid), 64'd1);
      chk("grant_index", 64'(gidx), 64'(pend_g));
      chk("busy_set", 64'(busy), 64'd1);
      pend = 1'b0;
    end
    if (|s_hdr_ready) begin
      if (exp_grant.size() != 0) begin
        g = exp_grant.pop_front();
        chk("grant_src", 64'(s_hdr_ready), 64'(4'(1) << g));
        pend   = 1'b1;
        pend_g = g;
      end else begin
        chk("unexp_grant", 64'(s_hdr_ready), 64'd0);
      end
      hdr_fires++;
    end
    for (int i = 0; i < S; i++) begin
      if (s_hdr_valid[i] && s_hdr_ready[i]) void'(hq[i].pop_front());
      if (s_tvalid[i] && s_tready[i])       void'(bq[i].pop_front());
    end
    if (m_hdr_valid && m_hdr_ready) begin
      if (exp_hdr.size() != 0) begin
        e = exp_hdr.pop_front();
        chk("hdr_type", 64'(m_type), 64'(e[15:0]));
        chk("hdr_dmac", 64'(m_dest), 64'(dmac(int'(e[17:16]))));
        chk("hdr_smac", 64'(m_src), 64'(smac(int'(e[17:16]))));
      end else begin
        chk("unexp_hdr", 64'(m_hdr_valid), 64'd0);
      end
    end
    if (m_tvalid && m_tready) begin
      if (exp_beat.size() != 0) begin
        b = exp_beat.pop_front();
        chk("beat", 64'({m_tuser, m_tlast, m_tdata}), 64'(b));
        chk("tkeep", 64'(m_tkeep), 64'd1);
      end else begin
        chk("unexp_beat", 64'(m_tvalid), 64'd0);
      end
      out_beats++;
    end
    if (|f_hdr_ready) begin
      chk("fp_grant", 64'(f_hdr_ready), 64'(4'b0010));
      fp_grants++;
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string tag, int budget);
    int n;
    n = 0;
    while ((exp_beat.size() + exp_hdr.size() + exp_grant.size()) != 0 &&
           n < budget) begin
      cycle();
      n++;
    end
    chk(tag, 64'(exp_beat.size() + exp_hdr.size() + exp_grant.size()), 64'd0);
    cycle();
    cycle();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    pend = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    int n, b0;
    rst       = 1'b1;
    bp        = 1'b0;
    hdr_hold  = 0;
    m_tready  = 1'b1;
    pend      = 1'b0;
    hdr_fires = 0;
    out_beats = 0;
    fp_grants = 0;
    drive();
    #2;
    chk("rst_hdr_valid", 64'(m_hdr_valid), 64'd0);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_tuser", 64'(m_tuser), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gidx", 64'(gidx), 64'd0);
    chk("rst_type", 64'(m_type), 64'd0);
    chk("rst_dmac", 64'(m_dest), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_s_hdr_ready", 64'(s_hdr_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    cycle();

    add_frame(2, 16'h0800, 3, 8'hAA, 8'h11, 1'b0);
    drain("t1_drain", 40);
    chk("t1_gidx", 64'(gidx), 64'd2);
    chk("t1_busy", 64'(busy), 64'd0);

    reset_dut();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < S; i++)
        add_frame(i, 16'h8800 + 16'(r * 16 + i), 2,
                  8'(i * 16 + r * 64), 8'h01, i == 3);
    drain("t2_drain", 80);

    reset_dut();
    bp = 1'b1;
    add_frame(0, 16'h86dd, 8, 8'h10, 8'h01, 1'b1);
    drain("t3_drain", 80);
    bp = 1'b0;

    reset_dut();
    hdr_hold = 10;
    add_frame(0, 16'h0806, 1, 8'h55, 8'h01, 1'b0);
    add_frame(1, 16'h0807, 1, 8'h66, 8'h01, 1'b0);
    n  = hdr_fires;
    b0 = out_beats;
    repeat (8) cycle();
    chk("stall_grants", 64'(hdr_fires - n), 64'd1);
    chk("stall_src0_out", 64'(out_beats - b0), 64'd1);
    chk("stall_src1_hdr", 64'(s_hdr_valid[1] & ~s_hdr_ready[1]), 64'd1);
    drain("t4_drain", 40);

    reset_dut();
    add_frame(0, 16'h0800, 5, 8'h30, 8'h01, 1'b0);
    n  = 0;
    b0 = out_beats;
    while (out_beats - b0 < 2 && n < 40) begin
      cycle();
      n++;
    end
    chk("t5_two_beats", 64'(out_beats - b0), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_tvalid", 64'(m_tvalid), 64'd0);
    chk("t5_hdr_valid", 64'(m_hdr_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_s_tready", 64'(s_tready), 64'd0);
    chk("t5_s_hdr_ready", 64'(s_hdr_ready), 64'd0);
    for (int i = 0; i < S; i++) begin
      hq[i].delete();
      bq[i].delete();
    end
    exp_beat.delete();
    exp_hdr.delete();
    exp_grant.delete();
    pend = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    cycle();
    add_frame(0, 16'h0801, 1, 8'h77, 8'h01, 1'b0);
    drain("t5_drain", 40);
    chk("t5_gidx", 64'(gidx), 64'd0);

    chk("fp_grants_seen", 64'(fp_grants > 5), 64'd1);
    chk("fp_gidx", 64'(f_gidx), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
